// File: rtl/sample_mix_sequencer.sv
// Frame-synchronous voice mixer: polls up to four voices once per 1024-cycle frame,
// accumulates their samples, applies a saturating gain shift and strobes the result out.
module sample_mix_sequencer (
  input  logic               clk_in,
  input  logic               reset_in,
  output logic [9:0]         master_count_out,
  input  logic [3:0]         voice_en_in,
  input  logic [1:0]         gain_in,
  output logic [1:0]         voice_sel_out,
  output logic               voice_req_out,
  input  logic               voice_ack_in,
  input  logic signed [11:0] voice_data_in,
  output logic signed [15:0] data_out,
  output logic               data_valid_out,
  output logic [3:0]         timeout_out
);

  typedef enum logic [2:0] {IDLE, REQ, NEXT, SCALE, OUT} state_t;

  localparam logic [9:0] FRAME_START = 10'd32;
  localparam logic [3:0] REQ_LIMIT   = 4'd15;

  state_t             state, state_nx;
  logic [9:0]         count;
  logic [3:0]         en_mask, en_mask_nx;
  logic [1:0]         gain, gain_nx;
  logic [1:0]         sel, sel_nx;
  logic signed [13:0] acc, acc_nx;
  logic [3:0]         wait_cnt, wait_nx;
  logic [3:0]         timeout, timeout_nx;
  logic signed [15:0] mix, mix_nx;
  logic [2:0]         first_voice, next_voice;

  // Returns {found, index} of the lowest enabled voice at or above 'from'.
  function automatic logic [2:0] find_voice(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

  function automatic logic signed [15:0] scale_sat(input logic signed [13:0] a,
                                                   input logic [1:0] sh);
    logic signed [16:0] w;
    w = {{3{a[13]}}, a};
    w = w <<< sh;
    if (w > 17'sd32767)       return 16'sh7FFF;
    else if (w < -17'sd32768) return 16'sh8000;
    else                      return w[15:0];
  endfunction

  always_comb begin
    state_nx    = state;
    en_mask_nx  = en_mask;
    gain_nx     = gain;
    sel_nx      = sel;
    acc_nx      = acc;
    wait_nx     = wait_cnt;
    timeout_nx  = timeout;
    mix_nx      = mix;
    first_voice = find_voice(voice_en_in, 3'd0);
    next_voice  = find_voice(en_mask, {1'b0, sel} + 3'd1);
    case (state)
      IDLE: begin
        if (count == FRAME_START) begin
          en_mask_nx = voice_en_in;
          gain_nx    = gain_in;
          acc_nx     = '0;
          wait_nx    = '0;
          if (first_voice[2]) begin
            sel_nx   = first_voice[1:0];
            state_nx = REQ;
          end else begin
            state_nx = SCALE;
          end
        end
      end
      REQ: begin
        if (voice_ack_in) begin
          acc_nx   = acc + {{2{voice_data_in[11]}}, voice_data_in};
          state_nx = NEXT;
        end else if (wait_cnt == REQ_LIMIT) begin
          timeout_nx[sel] = 1'b1;
          state_nx        = NEXT;
        end else begin
          wait_nx = wait_cnt + 4'd1;
        end
      end
      NEXT: begin
        wait_nx = '0;
        if (next_voice[2]) begin
          sel_nx   = next_voice[1:0];
          state_nx = REQ;
        end else begin
          state_nx = SCALE;
        end
      end
      SCALE: begin
        mix_nx   = scale_sat(acc, gain);
        state_nx = OUT;
      end
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state    <= IDLE;
      count    <= '0;
      en_mask  <= '0;
      gain     <= '0;
      sel      <= '0;
      acc      <= '0;
      wait_cnt <= '0;
      timeout  <= '0;
      mix      <= '0;
    end else begin
      state    <= state_nx;
      count    <= count + 10'd1;
      en_mask  <= en_mask_nx;
      gain     <= gain_nx;
      sel      <= sel_nx;
      acc      <= acc_nx;
      wait_cnt <= wait_nx;
      timeout  <= timeout_nx;
      mix      <= mix_nx;
    end
  end

  assign master_count_out = count;
  assign voice_sel_out    = sel;
  assign voice_req_out    = (state == REQ);
  assign data_valid_out   = (state == OUT);
  assign data_out         = mix;
  assign timeout_out      = timeout;

endmodule

// File: tb/tb_sample_mix_sequencer.sv
// Directed bench for sample_mix_sequencer: a scripted voice responder plus frame-level checks.
module tb_sample_mix_sequencer;

  logic               clk_in;
  logic               reset_in;
  logic [9:0]         master_count_out;
  logic [3:0]         voice_en_in;
  logic [1:0]         gain_in;
  logic [1:0]         voice_sel_out;
  logic               voice_req_out;
  logic               voice_ack_in;
  logic signed [11:0] voice_data_in;
  logic signed [15:0] data_out;
  logic               data_valid_out;
  logic [3:0]         timeout_out;

  sample_mix_sequencer dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .master_count_out (master_count_out),
    .voice_en_in      (voice_en_in),
    .gain_in          (gain_in),
    .voice_sel_out    (voice_sel_out),
    .voice_req_out    (voice_req_out),
    .voice_ack_in     (voice_ack_in),
    .voice_data_in    (voice_data_in),
    .data_out         (data_out),
    .data_valid_out   (data_valid_out),
    .timeout_out      (timeout_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int errors = 0;
  int checks = 0;

  logic signed [11:0] vd [4];
  logic [3:0] mute;
  logic       junk;
  int         dly;
  int         age;
  logic       prev_req;
  int         nreq;
  logic [7:0] selseq;
  int         reqlen [4];
  int         vpulses;
  logic [15:0] vval;
  int         vat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: respond as the selected voice and record what the DUT did.
  task automatic step();
    @(posedge clk_in);
    #1;
    if (voice_req_out) begin
      if (!prev_req) begin
        selseq = {selseq[5:0], voice_sel_out};
        nreq++;
      end
      reqlen[voice_sel_out]++;
      age++;
      voice_ack_in  = !mute[voice_sel_out] && (age > dly);
      voice_data_in = vd[voice_sel_out];
    end else begin
      age           = 0;
      voice_ack_in  = junk;
      voice_data_in = 12'sh7FF;
    end
    if (data_valid_out) begin
      vpulses++;
      vval = data_out;
      vat  = int'(master_count_out);
    end
    prev_req = voice_req_out;
  endtask

  task automatic clear_stats();
    nreq = 0; selseq = '0; vpulses = 0; vval = '0; vat = -1;
    for (int i = 0; i < 4; i++) reqlen[i] = 0;
  endtask

  // Runs one frame; inputs are scrambled mid-frame to show they are latched.
  task automatic frame(input logic [3:0] en, input logic [1:0] g);
    clear_stats();
    for (int i = 0; i < 1100 && master_count_out != 10'd31; i++) step();
    check("frame_sync", 32'(master_count_out), 32'd31);
    voice_en_in = en;
    gain_in     = g;
    repeat (9) step();
    voice_en_in = ~en;
    gain_in     = ~g;
    repeat (91) step();
  endtask

  initial begin
    reset_in = 1'b1; voice_en_in = '0; gain_in = '0;
    voice_ack_in = 1'b0; voice_data_in = '0;
    mute = '0; junk = 1'b0; dly = 0; age = 0; prev_req = 1'b0;
    for (int i = 0; i < 4; i++) vd[i] = '0;
    clear_stats();

    repeat (3) step();
    check("rst_count", 32'(master_count_out), 32'd0);
    check("rst_req", 32'(voice_req_out), 32'd0);
    check("rst_valid", 32'(data_valid_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_timeout", 32'(timeout_out), 32'd0);
    check("rst_sel", 32'(voice_sel_out), 32'd0);
    reset_in = 1'b0;

    // Four voices, ack after two cycles, stray acks outside REQ
    vd[0] = 12'sd100; vd[1] = -12'sd50; vd[2] = 12'sd300; vd[3] = 12'sd7;
    dly = 2; junk = 1'b1;
    frame(4'b1111, 2'd0);
    junk = 1'b0;
    check("a_data", 32'(vval), 32'h0165);
    check("a_pulses", vpulses, 32'd1);
    check("a_timeout", 32'(timeout_out), 32'd0);
    check("a_nreq", nreq, 32'd4);
    check("a_selseq", 32'(selseq), 32'h1B);
    check("a_valid_at", vat, 32'd50);
    check("a_reqlen0", reqlen[0], 32'd3);

    // Voices 0 and 2 at full scale, gain 3
    for (int i = 0; i < 4; i++) vd[i] = 12'sd2047;
    dly = 0;
    frame(4'b0101, 2'd3);
    check("b_data", 32'(vval), 32'h7FF0);
    check("b_selseq", 32'(selseq), 32'h02);
    check("b_nreq", nreq, 32'd2);
    check("b_valid_at", vat, 32'd38);

    // Negative saturation
    for (int i = 0; i < 4; i++) vd[i] = -12'sd2048;
    frame(4'b1111, 2'd3);
    check("c_data", 32'(vval), 32'h8000);

    // Voice 1 never answers
    for (int i = 0; i < 4; i++) vd[i] = 12'sd10;
    mute = 4'b0010;
    frame(4'b1111, 2'd0);
    check("d_reqlen1", reqlen[1], 32'd16);
    check("d_timeout", 32'(timeout_out), 32'b0010);
    check("d_data", 32'(vval), 32'd30);
    mute = 4'b0000;
    frame(4'b1111, 2'd0);
    check("e_timeout_sticky", 32'(timeout_out), 32'b0010);
    check("e_data", 32'(vval), 32'd40);

    // Empty mask
    frame(4'b0000, 2'd2);
    check("f_nreq", nreq, 32'd0);
    check("f_pulses", vpulses, 32'd1);
    check("f_valid_at", vat, 32'd34);
    check("f_data", 32'(vval), 32'd0);

    // Reset in the middle of a request
    mute = 4'b1111;
    clear_stats();
    for (int i = 0; i < 1100 && master_count_out != 10'd31; i++) step();
    voice_en_in = 4'b1111; gain_in = 2'd1;
    repeat (9) step();
    check("g_req_before", 32'(voice_req_out), 32'd1);
    check("g_count_before", 32'(master_count_out), 32'd40);
    reset_in = 1'b1;
    step();
    check("g_req_dropped", 32'(voice_req_out), 32'd0);
    check("g_count_zero", 32'(master_count_out), 32'd0);
    reset_in = 1'b0;
    mute = 4'b0000; dly = 0;
    vd[0] = 12'sd1; vd[1] = 12'sd2; vd[2] = 12'sd3; vd[3] = 12'sd4;
    repeat (32) step();
    check("g_count32", 32'(master_count_out), 32'd32);
    check("g_no_pulse", vpulses, 32'd0);
    repeat (30) step();
    check("g_pulses", vpulses, 32'd1);
    check("g_data", 32'(vval), 32'd20);
    check("g_timeout", 32'(timeout_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_mix_sequencer.md
SAMPLE_MIX_SEQUENCER -- requirements
Module: sample_mix_sequencer

Interface
REQ-001 SHALL have clk_in  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have reset_in  input  1  reset; synchronous and active-high.
REQ-003 SHALL have master_count_out  output  10  free-running frame counter; drives the serializer timing bus (bit4 = bclk, bit9 = ws).
REQ-004 SHALL have voice_en_in  input  4  per-voice enable mask, latched at frame start.
REQ-005 SHALL have gain_in  input  2  post-mix left-shift amount (0..3), latched at frame start.
REQ-006 SHALL have voice_sel_out  output  2  index of the voice currently being requested.
REQ-007 SHALL have voice_req_out  output  1  sample request to the selected voice.
REQ-008 SHALL have voice_ack_in  input  1  selected voice presents a valid sample.
REQ-009 SHALL have voice_data_in  input  12  signed two's-complement sample from the selected voice, valid when ack is high.
REQ-010 SHALL have data_out  output  16  signed mixed sample to the serializer.
REQ-011 SHALL have data_valid_out  output  1  one-cycle strobe; data_out is valid in that cycle.
REQ-012 SHALL have timeout_out  output  4  sticky per-voice timeout flags.

Function
REQ-013 master_count_out SHALL increment by 1 every cycle and wrap 1023 -> 0.
REQ-014 Frame start SHALL be the cycle with master_count_out == 32, the first cycle after the serializer load point at count 31.
REQ-015 FSM states SHALL be IDLE, REQ, NEXT, SCALE, OUT.
REQ-016 IDLE: at frame start, SHALL latch voice_en_in and gain_in and clear the 14-bit signed accumulator.
REQ-017 IDLE: in the frame-start cycle, SHALL go to REQ with the lowest enabled index, or to SCALE if the mask is 0.
REQ-018 REQ: voice_req_out SHALL be 1 and voice_sel_out SHALL be stable until exit.
REQ-019 REQ: in the first cycle with voice_ack_in == 1, SHALL add sign-extended voice_data_in to the accumulator and go to NEXT.
REQ-020 REQ: after 16 cycles with req high and no ack, SHALL go to NEXT, add 0 and set timeout_out[sel].
REQ-021 voice_ack_in SHALL be ignored outside REQ.
REQ-022 NEXT: voice_req_out SHALL be 0 for this cycle, which guarantees a 1-cycle gap between requests.
REQ-023 NEXT: SHALL go to REQ with the next higher enabled index; with none remaining, SHALL go to SCALE.
REQ-024 SCALE: SHALL compute acc <<< gain.
REQ-025 SCALE: a result above 32767 SHALL saturate to 32767 (0x7FFF), and a result below -32768 to -32768 (0x8000); the result SHALL register into data_out.
REQ-026 OUT: data_valid_out SHALL be 1 for exactly this cycle, then the FSM SHALL return to IDLE.
REQ-027 data_out SHALL hold its value until the next SCALE.
REQ-028 Worst-case frame (4 voices, all timeouts) SHALL finish by count 32+1+4*17+2 = 103, well before the next load at count 31.
REQ-029 Frame start while not in IDLE is unreachable by REQ-028; the FSM SHALL ignore it if reached.
REQ-030 Changes on voice_en_in and gain_in mid-frame SHALL take effect only at the next frame start.
REQ-031 timeout_out bits SHALL clear only on reset; a later successful ack SHALL NOT clear them.

Reset
REQ-032 On reset_in == 1 at a clock edge, the next-state values SHALL be: master_count_out = 0, FSM = IDLE, accumulator = 0, voice_req_out = 0, voice_sel_out = 0, data_out = 0, data_valid_out = 0, timeout_out = 0, latched enable/gain = 0.
REQ-033 Reset asserted mid-request SHALL drop voice_req_out at the next edge, with no accumulation and no data_valid_out pulse.
REQ-034 After reset release, the first frame start SHALL occur 32 cycles later.

Verification
REQ-035 Four enabled voices ack 2 cycles after each req with data 100, -50, 300, 7 and gain 0 -> data_out = 357, a single valid pulse, timeout_out = 0.
REQ-036 voice_en_in = 0101, both voices ack immediately with 2047, gain 3 -> sel sequence 0,2; acc 4094 <<< 3 = 32752 -> data_out = 0x7FF0.
REQ-037 Four voices at -2048 each, gain 3 -> acc -8192 <<< 3 = -65536 -> saturates, data_out = 0x8000.
REQ-038 Voice 1 never acks, others ack with 10 -> req to voice 1 held exactly 16 cycles, timeout_out = 0010, data_out = 30, and the flag persists in the next frame.
REQ-039 voice_en_in = 0000 -> no requests; data_valid_out pulses 2 cycles after frame start with data_out = 0.
REQ-040 Reset asserted at count 40 during REQ -> req low on the next edge, counter = 0, no valid pulse; normal mixing resumes at the next count 32.
